// File: rtl/regwr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regwr_arbiter
//  Purpose  : Shares the register file's single write port between three
//             producers (memory load return, shift unit, ALU writeback).
//             Keeps a load scoreboard and raises Stall when decode reads a
//             register that still has a load outstanding.
//  Revision : 1.0 - initial release
//
//  Ports
//    Clk, Reset                 clock (rising edge), synchronous active-low reset
//    AluReq/AluAddr/AluData     ALU write request             -> AluGrant
//    MemReq/MemAddr/MemData     load-return write request     -> MemGrant
//    ShReq/ShData               shift-unit request, writes R7 -> ShGrant
//    Reserve/ReserveAddr        load issued: mark register busy
//    RaddrA/RaddrB              decode read addresses         -> Stall
//    ResvErr                    sticky: Reserve hit a busy register
//    WriteEn/Waddr/DataIn       registered write port to the register file
//
//  Configuration
//    REGWR_RR_EN  defined   : round-robin Mem -> Sh -> Alu -> Mem
//                 undefined : fixed priority Mem > Sh > Alu
// ============================================================================
module regwr_arbiter #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluReq,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluGrant,
    input  logic         MemReq,
    input  logic [D-1:0] MemAddr,
    input  logic [W-1:0] MemData,
    output logic         MemGrant,
    input  logic         ShReq,
    input  logic [W-1:0] ShData,
    output logic         ShGrant,
    input  logic         Reserve,
    input  logic [D-1:0] ReserveAddr,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    output logic         Stall,
    output logic         ResvErr,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn
);

    localparam int         c_NREG     = 2**D;
    localparam logic [D-1:0] c_SH_ADDR = D'(7);

    // Winner encoding; also used as the round-robin pointer encoding.
    localparam logic [1:0] c_SEL_MEM  = 2'd0;
    localparam logic [1:0] c_SEL_SH   = 2'd1;
    localparam logic [1:0] c_SEL_ALU  = 2'd2;
    localparam logic [1:0] c_SEL_NONE = 2'd3;

    logic [c_NREG-1:0] r_busy;
    logic              r_resvErr;
    logic              r_writeEn;
    logic [D-1:0]      r_waddr;
    logic [W-1:0]      r_dataIn;

    logic              w_memElig;
    logic              w_shElig;
    logic              w_aluElig;
    logic [1:0]        w_sel;
    logic              w_memGrant;
    logic              w_shGrant;
    logic              w_aluGrant;
    logic              w_anyGrant;
    logic [D-1:0]      w_wAddr;
    logic [W-1:0]      w_wData;
    logic [c_NREG-1:0] w_setMask;
    logic [c_NREG-1:0] w_clrMask;
    logic [c_NREG-1:0] w_busyNext;
    logic              w_resvConflict;

    // A load return is always eligible: it is what releases a busy register,
    // so holding it off could deadlock the scoreboard.
    assign w_memElig = MemReq;
    assign w_shElig  = ShReq  & ~r_busy[c_SH_ADDR];
    assign w_aluElig = AluReq & ~r_busy[AluAddr];

`ifdef REGWR_RR_EN
    // ------------------------------------------------------------------
    // Round-robin: r_ptr names the requester with highest priority.
    // ------------------------------------------------------------------
    logic [1:0] r_ptr;
    logic [1:0] w_ptrNext;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ptr <= c_SEL_MEM;
        end else begin
            r_ptr <= w_ptrNext;
        end
    end

    // Winner selection, rotating the search order from the pointer
    always_comb begin
        w_sel = c_SEL_NONE;
        case (r_ptr)
            c_SEL_SH: begin
                if      (w_shElig)  w_sel = c_SEL_SH;
                else if (w_aluElig) w_sel = c_SEL_ALU;
                else if (w_memElig) w_sel = c_SEL_MEM;
            end
            c_SEL_ALU: begin
                if      (w_aluElig) w_sel = c_SEL_ALU;
                else if (w_memElig) w_sel = c_SEL_MEM;
                else if (w_shElig)  w_sel = c_SEL_SH;
            end
            default: begin
                if      (w_memElig) w_sel = c_SEL_MEM;
                else if (w_shElig)  w_sel = c_SEL_SH;
                else if (w_aluElig) w_sel = c_SEL_ALU;
            end
        endcase
    end

    // Next-state: pointer moves past the winner, holds when idle
    always_comb begin
        w_ptrNext = r_ptr;
        case (w_sel)
            c_SEL_MEM: w_ptrNext = c_SEL_SH;
            c_SEL_SH:  w_ptrNext = c_SEL_ALU;
            c_SEL_ALU: w_ptrNext = c_SEL_MEM;
            default:   w_ptrNext = r_ptr;
        endcase
    end
`else
    // ------------------------------------------------------------------
    // Fixed priority Mem > Sh > Alu; no pointer state.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = c_SEL_NONE;
        if      (w_memElig) w_sel = c_SEL_MEM;
        else if (w_shElig)  w_sel = c_SEL_SH;
        else if (w_aluElig) w_sel = c_SEL_ALU;
    end
`endif

    // ------------------------------------------------------------------
    // Grant outputs; held low for the whole time reset is asserted so a
    // request made during reset is never consumed.
    // ------------------------------------------------------------------
    always_comb begin
        w_memGrant = 1'b0;
        w_shGrant  = 1'b0;
        w_aluGrant = 1'b0;
        if (Reset) begin
            w_memGrant = (w_sel == c_SEL_MEM);
            w_shGrant  = (w_sel == c_SEL_SH);
            w_aluGrant = (w_sel == c_SEL_ALU);
        end
    end

    assign w_anyGrant = w_memGrant | w_shGrant | w_aluGrant;

    // Winner's address/data to be captured into the write port register
    always_comb begin
        w_wAddr = r_waddr;
        w_wData = r_dataIn;
        case (w_sel)
            c_SEL_MEM: begin
                w_wAddr = MemAddr;
                w_wData = MemData;
            end
            c_SEL_SH: begin
                w_wAddr = c_SH_ADDR;
                w_wData = ShData;
            end
            c_SEL_ALU: begin
                w_wAddr = AluAddr;
                w_wData = AluData;
            end
            default: begin
                w_wAddr = r_waddr;
                w_wData = r_dataIn;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard update. Set is applied after clear so a same-cycle
    // Reserve and load return to one address leaves it busy.
    // ------------------------------------------------------------------
    assign w_setMask  = Reserve    ? (c_NREG'(1) << ReserveAddr) : '0;
    assign w_clrMask  = w_memGrant ? (c_NREG'(1) << MemAddr)     : '0;
    assign w_busyNext = (r_busy & ~w_clrMask) | w_setMask;

    // Re-reserving a register whose load is returning this very cycle is legal.
    assign w_resvConflict = Reserve & r_busy[ReserveAddr]
                          & ~(w_memGrant & (MemAddr == ReserveAddr));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_busy    <= '0;
            r_resvErr <= 1'b0;
            r_writeEn <= 1'b0;
            r_waddr   <= '0;
            r_dataIn  <= '0;
        end else begin
            r_busy    <= w_busyNext;
            r_resvErr <= r_resvErr | w_resvConflict;
            r_writeEn <= w_anyGrant;
            if (w_anyGrant) begin
                r_waddr  <= w_wAddr;
                r_dataIn <= w_wData;
            end
        end
    end

    assign MemGrant = w_memGrant;
    assign ShGrant  = w_shGrant;
    assign AluGrant = w_aluGrant;
    assign Stall    = r_busy[RaddrA] | r_busy[RaddrB];
    assign ResvErr  = r_resvErr;
    assign WriteEn  = r_writeEn;
    assign Waddr    = r_waddr;
    assign DataIn   = r_dataIn;

endmodule
`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regwr_arbiter
//  Purpose  : Directed self-checking bench for regwr_arbiter. Inputs change
//             1 time unit after a rising edge; combinational outputs are
//             checked 2 units later, registered outputs right after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regwr_arbiter;

    localparam int W = 8;
    localparam int D = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         AluReq;
    logic [D-1:0] AluAddr;
    logic [W-1:0] AluData;
    logic         AluGrant;
    logic         MemReq;
    logic [D-1:0] MemAddr;
    logic [W-1:0] MemData;
    logic         MemGrant;
    logic         ShReq;
    logic [W-1:0] ShData;
    logic         ShGrant;
    logic         Reserve;
    logic [D-1:0] ReserveAddr;
    logic [D-1:0] RaddrA;
    logic [D-1:0] RaddrB;
    logic         Stall;
    logic         ResvErr;
    logic         WriteEn;
    logic [D-1:0] Waddr;
    logic [W-1:0] DataIn;

    int nChecks = 0;
    int nErrors = 0;

    always #5 Clk = ~Clk;

    regwr_arbiter #(.W(W), .D(D)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .AluReq     (AluReq),
        .AluAddr    (AluAddr),
        .AluData    (AluData),
        .AluGrant   (AluGrant),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .MemGrant   (MemGrant),
        .ShReq      (ShReq),
        .ShData     (ShData),
        .ShGrant    (ShGrant),
        .Reserve    (Reserve),
        .ReserveAddr(ReserveAddr),
        .RaddrA     (RaddrA),
        .RaddrB     (RaddrB),
        .Stall      (Stall),
        .ResvErr    (ResvErr),
        .WriteEn    (WriteEn),
        .Waddr      (Waddr),
        .DataIn     (DataIn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nErrors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit past the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    task automatic chkGrants(input string tag, input logic m, input logic s, input logic a);
        chk({tag, ".MemGrant"}, {31'd0, MemGrant}, {31'd0, m});
        chk({tag, ".ShGrant"},  {31'd0, ShGrant},  {31'd0, s});
        chk({tag, ".AluGrant"}, {31'd0, AluGrant}, {31'd0, a});
    endtask

    task automatic chkWrite(input string tag, input logic en, input logic [D-1:0] a, input logic [W-1:0] d);
        chk({tag, ".WriteEn"}, {31'd0, WriteEn}, {31'd0, en});
        if (en) begin
            chk({tag, ".Waddr"},  {28'd0, Waddr},  {28'd0, a});
            chk({tag, ".DataIn"}, {24'd0, DataIn}, {24'd0, d});
        end
    endtask

    initial begin
        Reset = 1'b0;
        AluReq = 1'b1; AluAddr = 4'd3; AluData = 8'hAA;
        MemReq = 1'b1; MemAddr = 4'd1; MemData = 8'hBB;
        ShReq  = 1'b1; ShData  = 8'hCC;
        Reserve = 1'b0; ReserveAddr = '0;
        RaddrA = '0; RaddrB = '0;

        // ---- Reset: requests presented but never granted ----
        settle();
        chkGrants("rst0", 1'b0, 1'b0, 1'b0);
        tick();
        chkGrants("rst1", 1'b0, 1'b0, 1'b0);
        chk("rst1.WriteEn", {31'd0, WriteEn}, 32'd0);
        chk("rst1.Stall",   {31'd0, Stall},   32'd0);
        chk("rst1.ResvErr", {31'd0, ResvErr}, 32'd0);
        tick();
        chkGrants("rst2", 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        AluReq = 1'b0; MemReq = 1'b0; ShReq = 1'b0;
        tick();
        chk("post.WriteEn", {31'd0, WriteEn}, 32'd0);
        chk("post.Stall",   {31'd0, Stall},   32'd0);
        chk("post.ResvErr", {31'd0, ResvErr}, 32'd0);
        chk("post.Waddr",   {28'd0, Waddr},   32'd0);
        chk("post.DataIn",  {24'd0, DataIn},  32'd0);

        // ---- Lone ALU write to R3 ----
        AluReq = 1'b1; AluAddr = 4'd3; AluData = 8'h5A;
        settle();
        chkGrants("alu", 1'b0, 1'b0, 1'b1);
        tick();
        AluReq = 1'b0;
        chkWrite("alu.wr", 1'b1, 4'd3, 8'h5A);
        tick();
        chkWrite("idle.wr", 1'b0, 4'd0, 8'h00);

        // ---- All three requesting for three cycles ----
        MemReq = 1'b1; MemAddr = 4'd1; MemData = 8'h11;
        ShReq  = 1'b1; ShData  = 8'h22;
        AluReq = 1'b1; AluAddr = 4'd5; AluData = 8'h33;
        settle();
        chkGrants("all0", 1'b1, 1'b0, 1'b0);
        tick();
        chkWrite("all0.wr", 1'b1, 4'd1, 8'h11);
        settle();
`ifdef REGWR_RR_EN
        chkGrants("all1", 1'b0, 1'b1, 1'b0);
        tick();
        chkWrite("all1.wr", 1'b1, 4'd7, 8'h22);
        settle();
        chkGrants("all2", 1'b0, 1'b0, 1'b1);
        tick();
        chkWrite("all2.wr", 1'b1, 4'd5, 8'h33);
`else
        chkGrants("all1", 1'b1, 1'b0, 1'b0);
        tick();
        chkWrite("all1.wr", 1'b1, 4'd1, 8'h11);
        settle();
        chkGrants("all2", 1'b1, 1'b0, 1'b0);
        tick();
        chkWrite("all2.wr", 1'b1, 4'd1, 8'h11);
`endif
        MemReq = 1'b0; ShReq = 1'b0; AluReq = 1'b0;
        tick();

        // ---- Load outstanding on R7 blocks the shift unit ----
        Reserve = 1'b1; ReserveAddr = 4'd7;
        tick();
        Reserve = 1'b0;
        ShReq = 1'b1; ShData = 8'h44; RaddrA = 4'd7;
        settle();
        chk("r7.ShGrant", {31'd0, ShGrant}, 32'd0);
        chk("r7.Stall",   {31'd0, Stall},   32'd1);
        tick();
        MemReq = 1'b1; MemAddr = 4'd7; MemData = 8'h77;
        settle();
        chkGrants("r7.ld", 1'b1, 1'b0, 1'b0);
        chk("r7.ld.Stall", {31'd0, Stall}, 32'd1);
        tick();
        MemReq = 1'b0;
        settle();
        chk("r7.rel.Stall",   {31'd0, Stall},   32'd0);
        chk("r7.rel.ShGrant", {31'd0, ShGrant}, 32'd1);
        chkWrite("r7.ld.wr", 1'b1, 4'd7, 8'h77);
        tick();
        ShReq = 1'b0; RaddrA = 4'd0;
        chkWrite("r7.sh.wr", 1'b1, 4'd7, 8'h44);

        // ---- Double reserve of R2 raises sticky ResvErr ----
        Reserve = 1'b1; ReserveAddr = 4'd2;
        tick();
        chk("resv.n1.ResvErr", {31'd0, ResvErr}, 32'd0);
        tick();
        Reserve = 1'b0; RaddrB = 4'd2;
        chk("resv.n2.ResvErr", {31'd0, ResvErr}, 32'd1);
        settle();
        chk("resv.Stall", {31'd0, Stall}, 32'd1);
        tick();
        chk("resv.hold.ResvErr", {31'd0, ResvErr}, 32'd1);

        // ---- Reserve R4 and load return to R4 in the same cycle ----
        Reserve = 1'b1; ReserveAddr = 4'd4;
        MemReq = 1'b1; MemAddr = 4'd4; MemData = 8'h99;
        RaddrB = 4'd4;
        settle();
        chk("same.Stall.pre", {31'd0, Stall}, 32'd0);
        chkGrants("same", 1'b1, 1'b0, 1'b0);
        tick();
        Reserve = 1'b0; MemReq = 1'b0;
        settle();
        chk("same.Stall", {31'd0, Stall}, 32'd1);
        chkWrite("same.wr", 1'b1, 4'd4, 8'h99);

        // ALU write to a busy register is held off without error
        AluReq = 1'b1; AluAddr = 4'd2; AluData = 8'h55;
        settle();
        chk("aluBusy.AluGrant", {31'd0, AluGrant}, 32'd0);
        tick();
        chkWrite("aluBusy.wr", 1'b0, 4'd0, 8'h00);
        AluReq = 1'b0;

        // ---- Reset clears the sticky error and the scoreboard ----
        Reset = 1'b0;
        tick();
        chk("rst.ResvErr", {31'd0, ResvErr}, 32'd0);
        chk("rst.Stall",   {31'd0, Stall},   32'd0);
        chk("rst.WriteEn", {31'd0, WriteEn}, 32'd0);
        Reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
